// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding and baud divider helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, phase reset by restart.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        tick  = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with 3-sample majority vote and a one-entry valid/ready output;
// dout_valid rises 1 clk after the final stop mid-sample, a frame arriving while held is dropped.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    uart_state_e          state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [TW-1:0]        tcnt_q, tcnt_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [1:0]           smp_q, smp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 stop_or_q, stop_or_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic                 break_q, break_d;

    logic line, tick, restart, mid, maj, frame_done;
    logic data_xor, perr_calc, is_break;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    assign sync_d = {sync_q[0], rx_serial};
    assign line   = sync_q[1];
    assign mid    = tick && (tcnt_q == T_MID);
    assign maj    = (smp_q[1] & smp_q[0]) | (smp_q[1] & line) | (smp_q[0] & line);

    // The tick counter free-runs modulo OVERSAMPLE from the start edge, so every
    // bit is sampled OVERSAMPLE ticks after the previous mid-sample.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bcnt_d     = bcnt_q;
        smp_d      = smp_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_or_d  = stop_or_q;
        ferr_acc_d = ferr_acc_q;
        restart    = 1'b0;
        frame_done = 1'b0;
        if (tick) begin
            tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);
            if (tcnt_q == T_S0) smp_d[0] = line;
            if (tcnt_q == T_S1) smp_d[1] = line;
        end
        case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                if (!line) begin
                    restart = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (mid) begin
                    bcnt_d     = '0;
                    stop_or_d  = 1'b0;
                    ferr_acc_d = 1'b0;
                    state_d    = maj ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (mid) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                    if (bcnt_q == BW'(DATA_BITS - 1)) begin
                        bcnt_d  = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (mid) begin
                    par_d   = maj;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (mid) begin
                    stop_or_d  = stop_or_q | maj;
                    ferr_acc_d = ferr_acc_q | ~maj;
                    if (bcnt_q == BW'(STOP_BITS - 1)) begin
                        frame_done = 1'b1;
                        state_d    = maj ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (line) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign data_xor  = (^shift_q) ^ par_q;
    assign perr_calc = (PARITY == PAR_EVEN) ? data_xor :
                       (PARITY == PAR_ODD)  ? ~data_xor : 1'b0;
    assign is_break  = (shift_q == '0) && ((PARITY == PAR_NONE) || !par_q) && !stop_or_d;

    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        overrun_d    = 1'b0;
        break_d      = 1'b0;
        if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
        if (frame_done) begin
            if (is_break) begin
                break_d = 1'b1;
            end else if (!dout_valid_q || dout_ready) begin
                dout_d       = shift_q;
                perr_d       = perr_calc;
                ferr_d       = ferr_acc_d;
                dout_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sync_q       <= 2'b11;
            tcnt_q       <= '0;
            bcnt_q       <= '0;
            smp_q        <= 2'b11;
            shift_q      <= '1;
            par_q        <= 1'b0;
            stop_or_q    <= 1'b0;
            ferr_acc_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tcnt_q       <= tcnt_d;
            bcnt_q       <= bcnt_d;
            smp_q        <= smp_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            stop_or_q    <= stop_or_d;
            ferr_acc_q   <= ferr_acc_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            overrun_q    <= overrun_d;
            break_q      <= break_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: a default 8N1 instance and a fast 7E2 instance driven from frame-level tasks.
module tb_uart_rx_cfg;

    typedef struct {
        int dut;
        int due;
        int data;
        int perr;
        int ferr;
        int brk;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] rx;
    logic [1:0] rdy;
    logic [1:0] val, perr, ferr, ovr, brk, busy;
    logic [7:0] dout0;
    logic [6:0] dout1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   rand_rdy = 0;
    exp_t exp_q[$];

    bit m_valid[2], m_perr[2], m_ferr[2], m_ovr[2], m_brk[2];
    int m_dout[2];
    int rise_cnt[2], rise_cyc[2], ovr_cnt[2], brk_cnt[2];
    int seen_dout[2], seen_perr[2], seen_ferr[2];
    bit prev_val[2];

    uart_rx_cfg u_dut0 (
        .clk(clk), .rst(rst), .rx_serial(rx[0]), .dout(dout0), .dout_valid(val[0]),
        .dout_ready(rdy[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]),
        .break_det(brk[0]), .busy(busy[0])
    );

    uart_rx_cfg #(
        .CLK_FREQ(3686400), .BAUD(115200), .OVERSAMPLE(8), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) u_dut1 (
        .clk(clk), .rst(rst), .rx_serial(rx[1]), .dout(dout1), .dout_valid(val[1]),
        .dout_ready(rdy[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]),
        .break_det(brk[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int d);  return d ? 4 : 27;  endfunction
    function automatic int os_of(input int d);   return d ? 8 : 16;  endfunction
    function automatic int dw_of(input int d);   return d ? 7 : 8;   endfunction
    function automatic int par_of(input int d);  return d ? 2 : 0;   endfunction
    function automatic int sb_of(input int d);   return d ? 2 : 1;   endfunction
    function automatic int dout_of(input int d); return d ? int'(dout1) : int'(dout0); endfunction

    // Clocks from driving the start edge to the edge that loads the output:
    // 1 to the first capture, 2 synchroniser stages, DIV-1 to the first tick,
    // then DIV per tick up to the final stop mid-sample, and 1 to register.
    function automatic int due_off(input int d);
        int nb;
        nb = 1 + dw_of(d) + ((par_of(d) != 0) ? 1 : 0) + sb_of(d);
        return 3 + div_of(d) + div_of(d) * (os_of(d) / 2 + 1 + os_of(d) * (nb - 1));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Caller is always positioned 1 time unit after a rising edge.
    task automatic send_frame(input int d, input int data, input int p, input int stops, input int gap);
        exp_t        e;
        logic [15:0] bits;
        int          n, x, smask, dw;
        dw    = dw_of(d);
        smask = (1 << sb_of(d)) - 1;
        bits  = '1;
        n     = 0;
        bits[n] = 1'b0;
        n++;
        x = p & 1;
        for (int i = 0; i < dw; i++) begin
            bits[n] = data[i];
            x ^= (data >> i) & 1;
            n++;
        end
        if (par_of(d) != 0) begin
            bits[n] = p[0];
            n++;
        end
        for (int s = 0; s < sb_of(d); s++) begin
            bits[n] = stops[s];
            n++;
        end
        e.dut  = d;
        e.data = data & ((1 << dw) - 1);
        e.perr = (par_of(d) == 2) ? x : (par_of(d) == 1) ? (x ^ 1) : 0;
        e.ferr = ((stops & smask) != smask) ? 1 : 0;
        e.brk  = (e.data == 0 && (par_of(d) == 0 || (p & 1) == 0) && (stops & smask) == 0) ? 1 : 0;
        e.due  = cyc + due_off(d);
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            rx[d] = bits[i];
            repeat (div_of(d) * os_of(d)) @(posedge clk);
            #1;
        end
        if (gap > 0) begin
            rx[d] = 1'b1;
            repeat (gap * div_of(d) * os_of(d)) @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_zero(input int d);
        chk(d ? "rst_valid1" : "rst_valid0", val[d], 0);
        chk(d ? "rst_dout1" : "rst_dout0", dout_of(d), 0);
        chk(d ? "rst_perr1" : "rst_perr0", perr[d], 0);
        chk(d ? "rst_ferr1" : "rst_ferr0", ferr[d], 0);
        chk(d ? "rst_ovr1" : "rst_ovr0", ovr[d], 0);
        chk(d ? "rst_brk1" : "rst_brk0", brk[d], 0);
        chk(d ? "rst_busy1" : "rst_busy0", busy[d], 0);
    endtask

    // Output-register model: decided at each rising edge from the frame queue.
    initial begin
        exp_t e;
        bit   was;
        forever begin
            @(posedge clk);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                m_ovr[d] = 0;
                m_brk[d] = 0;
                if (rst) begin
                    m_valid[d] = 0;
                end else begin
                    was = m_valid[d];
                    if (was && rdy[d]) m_valid[d] = 0;
                    if (exp_q.size() > 0 && exp_q[0].dut == d && exp_q[0].due == cyc) begin
                        e = exp_q.pop_front();
                        if (e.brk != 0) begin
                            m_brk[d] = 1;
                        end else if (!was || rdy[d]) begin
                            m_valid[d] = 1;
                            m_dout[d]  = e.data;
                            m_perr[d]  = e.perr[0];
                            m_ferr[d]  = e.ferr[0];
                        end else begin
                            m_ovr[d] = 1;
                        end
                    end
                end
            end
            if (rst) exp_q.delete();
        end
    end

    // Per-cycle comparison against the model, plus observation counters.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int d = 0; d < 2; d++) begin
                    chk(d ? "valid1" : "valid0", val[d], m_valid[d]);
                    chk(d ? "overrun1" : "overrun0", ovr[d], m_ovr[d]);
                    chk(d ? "break1" : "break0", brk[d], m_brk[d]);
                    if (m_valid[d]) begin
                        chk(d ? "dout1" : "dout0", dout_of(d), m_dout[d]);
                        chk(d ? "perr1" : "perr0", perr[d], m_perr[d]);
                        chk(d ? "ferr1" : "ferr0", ferr[d], m_ferr[d]);
                    end
                    if (val[d] && !prev_val[d]) begin
                        rise_cnt[d]++;
                        rise_cyc[d] = cyc;
                    end
                    if (val[d]) begin
                        seen_dout[d] = dout_of(d);
                        seen_perr[d] = perr[d];
                        seen_ferr[d] = ferr[d];
                    end
                    if (ovr[d]) ovr_cnt[d]++;
                    if (brk[d]) brk_cnt[d]++;
                end
            end
            prev_val[0] = val[0];
            prev_val[1] = val[1];
        end
    end

    initial begin
        rand_rdy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) rdy[1] = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int t0, base, base2, found, cleared, dv, dp, ds, gap;
        rst = 1'b1;
        rx  = 2'b11;
        rdy = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0);
        chk_zero(1);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Plain 8N1 frame and its exact latency.
        base = rise_cnt[0];
        t0   = cyc;
        send_frame(0, 'hA5, 0, 1, 1);
        chk("t1_dout", seen_dout[0], 'hA5);
        chk("t1_perr", seen_perr[0], 0);
        chk("t1_ferr", seen_ferr[0], 0);
        chk("t1_latency", rise_cyc[0] - t0, 4161);
        chk("t1_frames", rise_cnt[0] - base, 1);

        // Even parity on the 7E2 instance.
        t0 = cyc;
        send_frame(1, 'h03, 1, 3, 1);
        chk("t2_dout", seen_dout[1], 'h03);
        chk("t2_perr_bad", seen_perr[1], 1);
        chk("t2_latency", rise_cyc[1] - t0, 347);
        send_frame(1, 'h03, 0, 3, 1);
        chk("t2_perr_ok", seen_perr[1], 0);

        // Short low glitch is rejected as a false start.
        base = rise_cnt[0];
        rx[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (busy[0]) found = 1;
        end
        cleared = 0;
        for (int i = 0; i < 600 && cleared == 0; i++) begin
            @(negedge clk);
            if (!busy[0]) cleared = 1;
        end
        chk("t3_busy_seen", found, 1);
        chk("t3_busy_clear", cleared, 1);
        chk("t3_no_frame", rise_cnt[0] - base, 0);
        @(posedge clk);
        #1;
        send_frame(0, 'h5A, 0, 1, 1);
        chk("t3_dout", seen_dout[0], 'h5A);

        // Stop bit low: framing error, then wait for idle line.
        send_frame(0, 'h3C, 0, 0, 0);
        chk("t4_dout", seen_dout[0], 'h3C);
        chk("t4_ferr", seen_ferr[0], 1);
        chk("t4_wait_high", busy[0], 1);
        rx[0] = 1'b1;
        repeat (432) @(posedge clk);
        #1;
        chk("t4_idle", busy[0], 0);
        send_frame(0, 'h7E, 0, 1, 1);
        chk("t4_next_dout", seen_dout[0], 'h7E);
        chk("t4_next_ferr", seen_ferr[0], 0);

        // Overrun while the consumer stalls.
        base = ovr_cnt[0];
        rdy[0] = 1'b0;
        send_frame(0, 'h11, 0, 1, 0);
        send_frame(0, 'h22, 0, 1, 0);
        chk("t5_held_valid", val[0], 1);
        chk("t5_held_dout", dout0, 'h11);
        chk("t5_one_overrun", ovr_cnt[0] - base, 1);
        fork
            send_frame(0, 'h33, 0, 1, 1);
            begin
                repeat (due_off(0) - 1) @(posedge clk);
                #1;
                rdy[0] = 1'b1;
            end
        join
        chk("t5_dout", seen_dout[0], 'h33);
        chk("t5_no_more_overrun", ovr_cnt[0] - base, 1);

        // Break: line low for two frame times.
        base  = brk_cnt[0];
        base2 = rise_cnt[0];
        send_frame(0, 0, 0, 0, 0);
        repeat (10 * 432) @(posedge clk);
        #1;
        rx[0] = 1'b1;
        repeat (2 * 432) @(posedge clk);
        #1;
        chk("t6_break_once", brk_cnt[0] - base, 1);
        chk("t6_no_frame", rise_cnt[0] - base2, 0);

        // Reset in the middle of 0x99.
        rx[0] = 1'b0;
        repeat (432) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rx[0] = (i == 0) ? 1'b1 : 1'b0;
            repeat (432) @(posedge clk);
            #1;
        end
        rst   = 1'b1;
        rx[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero(0);
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = rise_cnt[0];
        repeat (5 * 432) @(posedge clk);
        #1;
        chk("t6_no_frame_after_rst", rise_cnt[0] - base, 0);
        send_frame(0, 'h42, 0, 1, 1);
        chk("t6_dout", seen_dout[0], 'h42);

        // Randomized 7E2 traffic with a randomly stalling consumer.
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            dv = $urandom_range(0, 127);
            dp = $urandom_range(0, 1);
            ds = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 3;
            if (i % 10 == 9) begin
                dv = 0;
                dp = 0;
                ds = 0;
            end
            gap = ((ds & 2) == 0) ? 1 : $urandom_range(0, 2);
            send_frame(1, dv, dp, ds, gap);
        end
        rand_rdy = 0;
        repeat (2) @(posedge clk);
        #1;
        rdy[1] = 1'b1;
        repeat (64) @(posedge clk);
        #1;
        chk("rand_queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
